// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring radix-2 divider (one quotient bit per cycle)
// with valid/ready request and response handshakes. Signed and unsigned operation,
// divide-by-zero and signed-overflow results follow RISC-V M semantics.
// Optional macro SEQ_DIVIDER_FLUSH_EN adds a 'flush' input that aborts CALC/DONE.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             ovf
`ifdef SEQ_DIVIDER_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;

    logic             flush_c;
    logic             accept_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH:0]   trial_c;
    logic [WIDTH-1:0] step_rem_c;
    logic [WIDTH-1:0] step_quo_c;

`ifdef SEQ_DIVIDER_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // flush masks the request handshake so a simultaneous request is ignored
    assign in_ready  = in_ready_q & ~flush_c;
    assign accept_c  = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;

    // One restoring step: shift {rem, quo} left, trial-subtract |B|, restore on borrow
    always_comb begin
        trial_c    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};
        step_rem_c = trial_c[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial_c[WIDTH-1:0];
        step_quo_c = {quo_q[WIDTH-2:0], ~trial_c[WIDTH]};
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        ovf_d       = ovf_q;
        a_neg_c     = is_signed & dividend[WIDTH-1];
        b_neg_c     = is_signed & divisor[WIDTH-1];

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    div_zero_d = 1'b0;
                    ovf_d      = 1'b0;
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        div_zero_d  = 1'b1;
                        state_d     = S_DONE;
                    end else if (is_signed && (dividend == MOST_NEG) && (divisor == '1)) begin
                        quotient_d  = dividend;
                        remainder_d = '0;
                        ovf_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = a_neg_c ? WIDTH'(-dividend) : dividend;
                        dsr_d     = b_neg_c ? WIDTH'(-divisor) : divisor;
                        neg_quo_d = a_neg_c ^ b_neg_c;
                        neg_rem_d = a_neg_c;
                        cnt_d     = CNT_W'(WIDTH - 1);
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = step_rem_c;
                quo_d = step_quo_c;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    // sign fix-up folded into the last iteration
                    quotient_d  = neg_quo_q ? WIDTH'(-step_quo_c) : step_quo_c;
                    remainder_d = neg_rem_q ? WIDTH'(-step_rem_c) : step_rem_c;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush_c && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): directed cases plus random
// operands against an arithmetic reference model; a monitor pops expectations.
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
    logic         ovf;
`ifdef SEQ_DIVIDER_FLUSH_EN
    logic         flush;
`endif

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
`ifdef SEQ_DIVIDER_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           acc;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic rand_bp;
    logic forced_ready;
    logic rnd_ready;
    assign out_ready = rand_bp ? rnd_ready : forced_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) rnd_ready = ($urandom_range(0, 3) != 0);

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference model: plain integer division with the RISC-V M special cases
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint sa;
        longint sb;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        e.acc = 0;
        e.lat = W + 1;
        if (b == 0) begin
            e.q   = {W{1'b1}};
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q   = a;
            e.r   = '0;
            e.ov  = 1'b1;
            e.lat = 1;
        end else if (s) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            e.q = 32'(sa / sb);
            e.r = 32'(sa % sb);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Monitor: compare each new result against the oldest expectation
    logic         prev_ov = 1'b0;
    logic [W-1:0] hold_q, hold_r;
    logic         hold_dz, hold_ov;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    checks   = checks + 1;
                    failures = failures + 1;
                    $display("FAIL spurious_result: out_valid=1 with no request pending (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_zero", W'(div_zero), W'(e.dz));
                    chk("ovf", W'(ovf), W'(e.ov));
                    chk("latency", W'(cyc - e.acc), W'(e.lat));
                end
                hold_q  = quotient;
                hold_r  = remainder;
                hold_dz = div_zero;
                hold_ov = ovf;
            end else if (out_valid && prev_ov) begin
                chk("hold_quotient", quotient, hold_q);
                chk("hold_remainder", remainder, hold_r);
                chk("hold_flags", W'({div_zero, ovf}), W'({hold_dz, hold_ov}));
            end
            if (out_valid) chk("in_ready_in_done", W'(in_ready), 32'd0);
            prev_ov = out_valid;
        end
    end

    // Issue one request; the expectation is queued with its accept cycle
    task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL req_timeout: in_ready got 0 expected 1 after %0d cycles", n);
            return;
        end
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        e         = model(a, b, s);
        e.acc     = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = $urandom_range(0, 1) != 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (exp_q.size() != 0 || !in_ready) begin
            failures = failures + 1;
            $display("FAIL drain_timeout: pending=%0d in_ready=%0b expected pending=0 in_ready=1", exp_q.size(), in_ready);
        end
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_wait", W'(out_valid), 32'd1);
    endtask

    // Abort an operation in CALC after ~10 cycles; expect idle and no result
    task automatic abort_mid_calc(input logic use_flush);
        rand_bp      = 1'b0;
        forced_ready = 1'b1;
        do_req(32'd123456, 32'd789, 1'b0);
        repeat (9) @(negedge clk);
`ifdef SEQ_DIVIDER_FLUSH_EN
        if (use_flush) flush = 1'b1;
        else rst = 1'b1;
`else
        rst = 1'b1;
`endif
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("abort_in_ready", W'(in_ready_q_view()), 32'd1);
        chk("abort_out_valid", W'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`ifdef SEQ_DIVIDER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (45) @(negedge clk);
        chk("abort_no_result", W'(out_valid), 32'd0);
        chk("abort_idle_ready", W'(in_ready), 32'd1);
    endtask

    // in_ready as seen with flush released (flush masks it combinationally)
    function automatic logic in_ready_q_view();
`ifdef SEQ_DIVIDER_FLUSH_EN
        return dut.in_ready_q;
`else
        return in_ready;
`endif
    endfunction

    initial begin
        logic [W-1:0] a, b;
        logic         s;
        int           k;
        rst          = 1'b1;
        in_valid     = 1'b0;
        is_signed    = 1'b0;
        dividend     = '0;
        divisor      = '0;
        rand_bp      = 1'b0;
        forced_ready = 1'b1;
`ifdef SEQ_DIVIDER_FLUSH_EN
        flush        = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(in_ready), 32'd1);
        chk("rst_out_valid", W'(out_valid), 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_flags", W'({div_zero, ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_req(32'd100, 32'd7, 1'b0);
        do_req(32'hFFFF_FF9C, 32'd7, 1'b1);
        do_req(32'd100, 32'hFFFF_FFF9, 1'b1);
        do_req(32'h1234_5678, 32'd0, 1'b0);
        do_req(32'h1234_5678, 32'd0, 1'b1);
        do_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_req(32'd5, 32'd9, 1'b0);
        do_req(32'h8000_0000, 32'd3, 1'b1);
        wait_drain();

        // Back-pressure: hold DONE for 10 cycles, then release
        forced_ready = 1'b0;
        do_req(32'd100, 32'd7, 1'b0);
        wait_out_valid();
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", W'(out_valid), 32'd1);
            chk("bp_in_ready", W'(in_ready), 32'd0);
        end
        forced_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", W'(in_ready), 32'd1);
        chk("release_out_valid", W'(out_valid), 32'd0);
        do_req(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_drain();

        // Random operands with random back-pressure
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            s = $urandom_range(0, 1) != 0;
            k = $urandom_range(0, 9);
            if (k == 0) b = '0;
            else if (k == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (k < 5) b = s && ($urandom_range(0, 1) != 0) ? W'(-$urandom_range(1, 20)) : W'($urandom_range(1, 20));
            else if (k == 5) a = W'($urandom_range(0, 50));
            do_req(a, b, s);
        end
        wait_drain();

        abort_mid_calc(1'b0);
`ifdef SEQ_DIVIDER_FLUSH_EN
        abort_mid_calc(1'b1);
`endif
        do_req(32'd1000, 32'd33, 1'b0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle iterative divider that performs the inverse of the multiply path. Produces the quotient and remainder of two WIDTH-bit operands.
- Sits beside the combinational ALU in the NPC execute stage.
- The execute stage issues operands through a valid/ready request and waits for the result through a valid/ready response.
- Restoring radix-2 algorithm, one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  request valid
- in_ready  output  1  divider can accept a request
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on accept
- dividend  input  WIDTH  dividend A; sampled on accept
- divisor  input  WIDTH  divisor B; sampled on accept
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  A / B, truncated toward zero
- remainder  output  WIDTH  A % B; sign follows the dividend
- div_zero  output  1  result came from a divide-by-zero request
- ovf  output  1  result came from signed overflow (most-negative / -1)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst: state updates only at a clk rising edge while rst=1.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, ovf=0, counter=0.
- Accept: a request is accepted on a cycle where in_valid && in_ready. Operands and is_signed are registered. in_ready is 1 only in IDLE.
- States:
  - IDLE. On accept: go to DONE if B==0 or signed overflow, else go to CALC.
  - CALC. Counter runs WIDTH-1 down to 0. Each cycle:
    - Shift the {rem, quo} register left by 1.
    - Trial-subtract |B| from the upper part.
    - If the result is non-negative, keep it and set quotient LSB=1; else restore and set LSB=0.
    - After the cycle where counter==0, go to DONE.
  - DONE. out_valid=1. Outputs are held stable until out_ready. On out_valid && out_ready, go to IDLE.
- Signed handling:
  - Magnitudes are taken on accept.
  - The quotient is negated if sign(A)^sign(B).
  - The remainder is negated if sign(A).
  - Fix-up is applied on the CALC->DONE transition, so it adds no extra cycle.
- Special cases (results bit-exact to RISC-V M):
  - B==0: quotient=all ones, remainder=A, div_zero=1.
  - Signed, A=1<<(WIDTH-1), B=all ones: quotient=A, remainder=0, ovf=1.
  - A special case reaches DONE on the cycle after accept (latency 1).
- Latency: normal accept-to-out_valid is WIDTH+1 cycles. For WIDTH=32, the request is accepted at cycle 0 and out_valid rises at cycle 33.
- Back-pressure: DONE holds indefinitely while out_ready=0. No new request is accepted while in DONE, because in_ready=0.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Handshake across back-to-back results: after DONE->IDLE, in_ready=1 on the next cycle. A new request cannot be accepted on the same cycle the result is taken.
- Reset mid-operation: rst in any state aborts the operation. The block returns to reset values on the next edge and no result is emitted.
- div_zero and ovf are cleared on every accept. They are valid only while out_valid=1.
- Unsigned mode: operands are used as-is, with no negation.
- Unsigned A < B gives quotient=0, remainder=A.

Optional Feature:
- Macro: SEQ_DIVIDER_FLUSH_EN.
- When defined: an extra port flush (input, 1) is present.
  - flush=1 in CALC or DONE forces IDLE on the next edge and clears out_valid.
  - flush in IDLE is a no-op, but any simultaneous request is ignored (in_ready reads 0 while flush=1).
  - rst has priority over flush.
- When not defined: the port is absent. An operation can only be aborted by rst.

Test Plan:
- Unsigned: A=100, B=7, is_signed=0 -> out_valid exactly 33 cycles after accept; quotient=14, remainder=2, div_zero=0, ovf=0.
- Signed: A=-100 (0xFFFFFF9C), B=7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE). Also A=100, B=-7 -> quotient=0xFFFFFFF2, remainder=2.
- Divide by zero: A=0x12345678, B=0, both modes -> out_valid 1 cycle after accept; quotient=0xFFFFFFFF, remainder=0x12345678, div_zero=1.
- Signed overflow: A=0x80000000, B=0xFFFFFFFF, is_signed=1 -> 1-cycle latency; quotient=0x80000000, remainder=0, ovf=1. The same operands unsigned -> quotient=0, remainder=0x80000000, full latency.
- Back-pressure and handshake:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout.
  - Release -> in_ready=1 the following cycle.
  - A second request, A=0xFFFFFFFF, B=1 unsigned -> quotient=0xFFFFFFFF, remainder=0.
- Reset mid-CALC: assert rst at cycle 10 of an operation -> next edge shows in_ready=1, out_valid=0, and no result appears afterward. With SEQ_DIVIDER_FLUSH_EN, repeat using flush and expect the same response.
